key_event_encoder: RTL and testbench

Converts the debounced key levels of the synthesizer keyboard into an ordered stream of press/release events and a monophonic gate/active-key pair. Sits directly downstream of the per-key DeBouncer instances, with one `out` per key concatenated into `keys`. Feeds the tone generator / note sequencer through a valid/ready event port. Events are lossless: the only exception is coalescing of repeated toggles on a key that is still waiting for service.

---
 rtl/key_event_encoder.sv | 139 +++++++++++++
 tb/tb_key_event_encoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// key_event_encoder
// Turns debounced key levels into an ordered press/release event stream
// (valid/ready, show-ahead queue) and a monophonic gate / last-note-priority
// active key.
// Optional build macro: KEY_EVENT_RELEASE_EN -- when defined, release events
// are queued as well; when undefined, only presses are reported and pending
// releases are discarded without using a queue slot.

module key_event_encoder #(
    parameter  int NUM_KEYS   = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int KEY_W      = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KEY_W-1:0]    evt_key,
    output logic                evt_press,
    output logic                gate,
    output logic [KEY_W-1:0]    active_key
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Registered state
    logic [NUM_KEYS-1:0]   r_keys_q;
    logic [NUM_KEYS-1:0]   r_pend;
    logic [KEY_W-1:0]      r_fifo_key [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_press;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [KEY_W-1:0]      r_active_key;
    logic                  r_gate;

    // Combinational next-state terms
    logic [NUM_KEYS-1:0]   w_chg;
    logic [NUM_KEYS-1:0]   w_elig;
    logic [NUM_KEYS-1:0]   w_drop;
    logic [NUM_KEYS-1:0]   w_grant;
    logic [NUM_KEYS-1:0]   w_pend_nxt;
    logic                  w_pop;
    logic                  w_can_push;
    logic                  w_push;
    logic [KEY_W-1:0]      w_gnt_key;
    logic                  w_gnt_press;
    logic [KEY_W-1:0]      w_held_low;
    logic [KEY_W-1:0]      w_active_nxt;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [KEY_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
        logic [KEY_W-1:0] idx;
        idx = {KEY_W{1'b0}};
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            idx = v[i] ? KEY_W'(i) : idx;
        end
        return idx;
    endfunction

    // Grant arbitration, pending update and active-key selection.
    always_comb begin
        w_chg = keys ^ r_keys_q;
`ifdef KEY_EVENT_RELEASE_EN
        w_elig = r_pend;
        w_drop = {NUM_KEYS{1'b0}};
`else
        // Releases never reach the queue: they are simply forgotten.
        w_elig = r_pend & r_keys_q;
        w_drop = r_pend & ~r_keys_q;
`endif
        w_pop       = (r_count != {CNT_W{1'b0}}) & evt_ready;
        // A pop in the same cycle frees the slot the push needs.
        w_can_push  = (r_count < DEPTH_C) | w_pop;
        w_push      = (|w_elig) & w_can_push;
        w_gnt_key   = lowest_idx(w_elig);
        w_gnt_press = r_keys_q[w_gnt_key];
        if (w_push) begin
            w_grant = w_elig & (~w_elig + NUM_KEYS'(1));
        end else begin
            w_grant = {NUM_KEYS{1'b0}};
        end
        // A fresh toggle re-arms the bit even if it is granted now.
        w_pend_nxt = (r_pend & ~w_grant & ~w_drop) | w_chg;
        w_held_low = lowest_idx(r_keys_q);
        if (w_push && w_gnt_press) begin
            w_active_nxt = w_gnt_key;
        end else if (!r_keys_q[r_active_key] && (|r_keys_q)) begin
            w_active_nxt = w_held_low;
        end else begin
            w_active_nxt = r_active_key;
        end
    end

    // Key sampling, pending bits, event queue and monophonic outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_keys_q     <= {NUM_KEYS{1'b0}};
            r_pend       <= {NUM_KEYS{1'b0}};
            r_fifo_press <= {FIFO_DEPTH{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_key[i] <= {KEY_W{1'b0}};
            end
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_rd_ptr     <= {PTR_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            r_active_key <= {KEY_W{1'b0}};
            r_gate       <= 1'b0;
        end else begin
            r_keys_q     <= keys;
            r_pend       <= w_pend_nxt;
            r_active_key <= w_active_nxt;
            r_gate       <= |r_keys_q;
            if (w_push) begin
                r_fifo_key[r_wr_ptr]   <= w_gnt_key;
                r_fifo_press[r_wr_ptr] <= w_gnt_press;
                r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign evt_valid  = (r_count != {CNT_W{1'b0}});
    assign evt_key    = r_fifo_key[r_rd_ptr];
    assign evt_press  = r_fifo_press[r_rd_ptr];
    assign gate       = r_gate;
    assign active_key = r_active_key;

endmodule

// File: tb/tb_key_event_encoder.sv
// Self-checking bench for key_event_encoder: directed scenarios followed by
// random key/ready/reset traffic, all compared against a queue-based
// reference model of the event and active-key rules.

module tb_key_event_encoder;

    localparam int NK    = 8;
    localparam int DEPTH = 4;
`ifdef KEY_EVENT_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] keys;
    logic          evt_valid;
    logic          evt_ready;
    logic [2:0]    evt_key;
    logic          evt_press;
    logic          gate;
    logic [2:0]    active_key;

    key_event_encoder #(.NUM_KEYS(NK), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .keys       (keys),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_key    (evt_key),
        .evt_press  (evt_press),
        .gate       (gate),
        .active_key (active_key)
    );

    always #5 clk = ~clk;

    typedef struct {
        int key;
        bit press;
    } ev_t;

    // Reference model state
    logic [NK-1:0] m_kq;
    logic [NK-1:0] m_pend;
    ev_t           m_q[$];
    int            m_act;
    bit            m_gate;

    int n_tests = 0;
    int n_fail  = 0;
    int popped_key[$];
    bit popped_press[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference behaviour, from pre-edge state and inputs.
    task automatic model_edge(input logic [NK-1:0] k, input bit rdy, input bit r);
        int  g;
        int  low;
        bit  pop;
        bit  canpush;
        bit  keep;
        if (r) begin
            m_kq   = '0;
            m_pend = '0;
            m_q.delete();
            m_act  = 0;
            m_gate = 1'b0;
        end else begin
            g       = -1;
            pop     = (m_q.size() > 0) && rdy;
            canpush = (m_q.size() < DEPTH) || pop;
            for (int i = 0; i < NK; i++) begin
                if (g < 0 && m_pend[i] && (REL || m_kq[i])) g = i;
            end
            if (!canpush) g = -1;
            if (pop) void'(m_q.pop_front());
            if (g >= 0) m_q.push_back('{key: g, press: m_kq[g]});
            low = 0;
            for (int i = NK - 1; i >= 0; i--) begin
                if (m_kq[i]) low = i;
            end
            if (g >= 0 && m_kq[g]) m_act = g;
            else if (!m_kq[m_act] && (m_kq != '0)) m_act = low;
            m_gate = (m_kq != '0);
            for (int i = 0; i < NK; i++) begin
                keep      = m_pend[i] && (i != g) && (REL || m_kq[i]);
                m_pend[i] = keep || (k[i] != m_kq[i]);
            end
            m_kq = k;
        end
    endtask

    task automatic check_model();
        chk("model_valid", evt_valid, (m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("model_key", evt_key, m_q[0].key);
            chk("model_press", evt_press, m_q[0].press);
        end
        chk("model_gate", gate, m_gate);
        chk("model_active", active_key, m_act);
    endtask

    task automatic step(input logic [NK-1:0] k, input bit rdy, input bit r);
        keys      = k;
        evt_ready = rdy;
        rst       = r;
        if (evt_valid === 1'b1 && rdy && !r) begin
            popped_key.push_back(int'(evt_key));
            popped_press.push_back(evt_press);
        end
        model_edge(k, rdy, r);
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        logic [NK-1:0] kr;
        bit            rr;
        bit            rdr;
        m_kq = '0; m_pend = '0; m_act = 0; m_gate = 1'b0;

        // 1. Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b1, 1'b1);
            chk("rst_valid", evt_valid, 1'b0);
            chk("rst_gate", gate, 1'b0);
            chk("rst_active", active_key, 3'd0);
        end

        // 2. Single press, two-edge latency, one-cycle event
        step(8'h08, 1'b1, 1'b0);
        chk("single_e0_valid", evt_valid, 1'b0);
        step(8'h08, 1'b1, 1'b0);
        chk("single_valid", evt_valid, 1'b1);
        chk("single_key", evt_key, 3'd3);
        chk("single_press", evt_press, 1'b1);
        chk("single_gate", gate, 1'b1);
        chk("single_active", active_key, 3'd3);
        step(8'h08, 1'b1, 1'b0);
        chk("single_after_valid", evt_valid, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 1'b0);

        // 3. Simultaneous press of keys 1 and 5
        step(8'h22, 1'b1, 1'b0);
        step(8'h22, 1'b1, 1'b0);
        chk("simul_first_key", evt_key, 3'd1);
        chk("simul_first_valid", evt_valid, 1'b1);
        step(8'h22, 1'b1, 1'b0);
        chk("simul_second_key", evt_key, 3'd5);
        chk("simul_second_valid", evt_valid, 1'b1);
        chk("simul_active", active_key, 3'd5);
        for (int i = 0; i < 6; i++) step(8'h00, 1'b1, 1'b0);

        // 4. Backpressure: six presses into a four-deep queue
        step(8'h01, 1'b0, 1'b0);
        kr = 8'h01;
        for (int i = 1; i < 6; i++) begin
            kr[i] = 1'b1;
            step(kr, 1'b0, 1'b0);
            chk("bp_hold_valid", evt_valid, 1'b1);
            chk("bp_hold_key", evt_key, 3'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step(8'h3F, 1'b0, 1'b0);
            chk("bp_hold_key", evt_key, 3'd0);
        end
        popped_key.delete();
        popped_press.delete();
        for (int i = 0; i < 9; i++) step(8'h3F, 1'b1, 1'b0);
        chk("bp_count", popped_key.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < popped_key.size()) begin
                chk("bp_order_key", popped_key[i], i);
                chk("bp_order_press", popped_press[i], 1'b1);
            end
        end
        for (int i = 0; i < 10; i++) step(8'h00, 1'b1, 1'b0);

        // 5. Release of the last note falls back to the remaining held key
        for (int i = 0; i < 3; i++) step(8'h04, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(8'h44, 1'b1, 1'b0);
        chk("fb_before_active", active_key, 3'd6);
        step(8'h04, 1'b1, 1'b0);
        step(8'h04, 1'b1, 1'b0);
        chk("fb_active", active_key, 3'd2);
        chk("fb_gate", gate, 1'b1);
        chk("fb_release_valid", evt_valid, REL);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 1'b0);

        // 6. Reset mid-operation flushes queued events
        step(8'h02, 1'b0, 1'b0);
        step(8'h06, 1'b0, 1'b0);
        step(8'h07, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        step(8'h01, 1'b0, 1'b0);
        chk("mid_queued_valid", evt_valid, 1'b1);
        step(8'h01, 1'b0, 1'b1);
        chk("mid_rst_valid", evt_valid, 1'b0);
        chk("mid_rst_gate", gate, 1'b0);
        chk("mid_rst_active", active_key, 3'd0);
        step(8'h01, 1'b1, 1'b0);
        chk("mid_e0_valid", evt_valid, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        chk("mid_e1_valid", evt_valid, 1'b1);
        chk("mid_e1_key", evt_key, 3'd0);
        chk("mid_e1_press", evt_press, 1'b1);
        step(8'h01, 1'b1, 1'b0);
        chk("mid_e2_valid", evt_valid, 1'b0);

        // Random traffic against the model
        kr = 8'h01;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < NK; b++) begin
                if ($urandom_range(0, 9) == 0) kr[b] = ~kr[b];
            end
            rr  = ($urandom_range(0, 119) == 0);
            rdr = ((c / 40) % 3 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            step(kr, rdr, rr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
